// File: rtl/dht11_sensor_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_sensor_rx_if
//  Description : Sensor-line and result bundle for the DHT11 poller.
//                slave  = the receiver block (samples the line, drives results)
//                master = the owning top (drives the sampled pad, reads results)
//  Revision    : 1.0  initial release
// ============================================================================
interface dht11_sensor_rx_if;
    logic       dht_in;
    logic       dht_out_en;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  dht_in,
        output dht_out_en,
        output humidity,
        output temperature,
        output data_valid,
        output frame_err,
        output busy
    );

    modport master (
        output dht_in,
        input  dht_out_en,
        input  humidity,
        input  temperature,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/dht11_sensor_rx.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_sensor_rx
//  Description : Periodic DHT11 single-wire poller. Issues the host start
//                pulse, times the sensor response, decodes the 40-bit frame
//                and publishes the integer humidity / temperature bytes.
//                Optional macro DHT11_CHECKSUM_EN: when defined, a frame whose
//                checksum byte disagrees with the 8-bit sum of the data bytes
//                is rejected; when undefined every complete frame is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module dht11_sensor_rx #(
    parameter int CLK_FREQ      = 12000000,
    parameter int POLL_MS       = 2000,
    parameter int START_MS      = 20,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst,
    dht11_sensor_rx_if.slave bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_us_div = (CLK_FREQ / 1000000 > 0) ? (CLK_FREQ / 1000000) : 1;
    localparam int c_div_w  = (c_us_div > 1) ? $clog2(c_us_div) : 1;
    localparam int c_ph_w   = $clog2(TIMEOUT_US + 1);
    localparam int c_ms_max = (POLL_MS > START_MS) ? POLL_MS : START_MS;
    localparam int c_ms_w   = $clog2(c_ms_max + 1);

    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(c_us_div - 1);
    localparam logic [c_ph_w-1:0]  c_timeout    = c_ph_w'(TIMEOUT_US);
    localparam logic [c_ph_w-1:0]  c_thresh     = c_ph_w'(BIT_THRESH_US);
    localparam logic [c_ms_w-1:0]  c_poll_last  = c_ms_w'(POLL_MS - 1);
    localparam logic [c_ms_w-1:0]  c_start_last = c_ms_w'(START_MS - 1);
    localparam logic [9:0]         c_us_last    = 10'd999;
    localparam logic [5:0]         c_last_bit   = 6'd39;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RELEASE = 3'd2,
        S_RESP_LO = 3'd3,
        S_RESP_HI = 3'd4,
        S_BIT_LO  = 3'd5,
        S_BIT_HI  = 3'd6,
        S_CHECK   = 3'd7
    } state_t;

    state_t              r_state;
    logic                r_sync1, r_sync2, r_sync3;
    logic [c_div_w-1:0]  r_div;
    logic [c_ph_w-1:0]   r_phase_us;
    logic [9:0]          r_ms_us;
    logic [c_ms_w-1:0]   r_ms_cnt;
    logic [39:0]         r_frame;
    logic [5:0]          r_bit_idx;
    logic                r_out_en;
    logic                r_busy;
    logic [7:0]          r_hum;
    logic [7:0]          r_tmp;
    logic                r_dv;
    logic                r_err;

    logic w_rise, w_fall;
    logic w_us_tick, w_ms_tick;
    logic w_timeout;
    logic w_adv, w_abort, w_leave;
    logic w_bit;
    logic w_good;

    // Two-flop synchronizer plus one history flop for edge detection; the
    // line idles high through its pull-up, so that is the reset value.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= bus.dht_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;

    // Free-running microsecond prescaler.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_us_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_us_tick = (r_div == c_div_last);
    assign w_ms_tick = w_us_tick && (r_ms_us == c_us_last);
    assign w_timeout = (r_phase_us == c_timeout);

    // A data bit is '1' only when its high time is strictly longer than the
    // threshold; the phase count lags the true width by one microsecond.
    assign w_bit = (r_phase_us >= c_thresh);

`ifdef DHT11_CHECKSUM_EN
    logic [7:0] w_sum;
    assign w_sum  = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
    assign w_good = (w_sum == r_frame[7:0]);
`else
    assign w_good = 1'b1;
`endif

    // Exit condition of the current state: expected event (w_adv) or a wait
    // that ran out of time (w_abort). Every exit is a real state change.
    always_comb begin
        w_adv   = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE:  w_adv = w_ms_tick && (r_ms_cnt == c_poll_last);
            S_START: w_adv = w_ms_tick && (r_ms_cnt == c_start_last);
            S_RELEASE, S_RESP_HI, S_BIT_HI: begin
                w_adv   = w_fall;
                w_abort = !w_fall && w_timeout;
            end
            S_RESP_LO, S_BIT_LO: begin
                w_adv   = w_rise;
                w_abort = !w_rise && w_timeout;
            end
            S_CHECK: w_adv = 1'b1;
            default: w_adv = 1'b0;
        endcase
    end

    assign w_leave = w_adv | w_abort;

    // Phase timers: cleared on every state change, advanced by the us tick.
    // The microsecond phase count saturates at the timeout value.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_leave) begin
            r_phase_us <= '0;
            r_ms_us    <= '0;
            r_ms_cnt   <= '0;
        end else if (w_us_tick) begin
            if (r_phase_us != c_timeout) begin
                r_phase_us <= r_phase_us + 1'b1;
            end
            if (r_ms_us == c_us_last) begin
                r_ms_us  <= '0;
                r_ms_cnt <= r_ms_cnt + 1'b1;
            end else begin
                r_ms_us  <= r_ms_us + 1'b1;
            end
        end
    end

    // Protocol sequencer with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_out_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_hum     <= 8'h00;
            r_tmp     <= 8'h00;
            r_dv      <= 1'b0;
            r_err     <= 1'b0;
            r_frame   <= '0;
            r_bit_idx <= '0;
        end else begin
            r_dv <= 1'b0;
            if (w_abort) begin
                // Timed-out wait: keep last good values, flag the frame.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else if (w_adv) begin
                case (r_state)
                    S_IDLE: begin
                        r_state  <= S_START;
                        r_out_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                    S_START: begin
                        r_state  <= S_RELEASE;
                        r_out_en <= 1'b0;
                    end
                    S_RELEASE: r_state <= S_RESP_LO;
                    S_RESP_LO: r_state <= S_RESP_HI;
                    S_RESP_HI: begin
                        r_state   <= S_BIT_LO;
                        r_bit_idx <= '0;
                    end
                    S_BIT_LO: r_state <= S_BIT_HI;
                    S_BIT_HI: begin
                        r_frame <= {r_frame[38:0], w_bit};
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_state   <= S_BIT_LO;
                        end
                    end
                    S_CHECK: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_good) begin
                            r_hum <= r_frame[39:32];
                            r_tmp <= r_frame[23:16];
                            r_dv  <= 1'b1;
                            r_err <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.dht_out_en  = r_out_en;
    assign bus.humidity    = r_hum;
    assign bus.temperature = r_tmp;
    assign bus.data_valid  = r_dv;
    assign bus.frame_err   = r_err;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire
